arbiter8_rr: RTL

Round-robin arbiter that shares one resource among eight requesters and drives a one-hot select bus, the same 3-bit-index-to-one-hot mapping as the team's 3-to-8 decoder. It sits in front of the shared resource: requesters raise `req`, exactly one holds the grant until it releases or times out, and the rotating priority pointer guarantees that no requester starves. The grant index and the one-hot grant are both registered outputs.

---
 rtl/arbiter8_rr.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/arbiter8_rr.sv
// -----------------------------------------------------------------------------
// arbiter8_rr
//   Round-robin arbiter for eight requesters. A grant is held until the owner
//   raises done, drops its request, or (when HOLD_MAX != 0) has held it for
//   HOLD_MAX cycles. After every release the priority pointer moves to the
//   requester just past the last owner, and at least one idle cycle passes
//   before the next grant.
//
// Parameters
//   HOLD_MAX  maximum grant length in cycles, 0 disables the timeout (0..255)
//
// Ports
//   clk      in   1  clock, rising edge
//   rst_n    in   1  synchronous active-low reset
//   req      in   8  request vector, bit i = requester i
//   done     in   1  current owner is finished (ignored while idle)
//   gnt      out  8  one-hot grant, zero while idle
//   gnt_idx  out  3  index of the current or most recent owner
//   busy     out  1  a grant is active
//   timeout  out  1  one-cycle pulse after a grant is revoked by HOLD_MAX
// -----------------------------------------------------------------------------
module arbiter8_rr #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The last permitted hold count; only meaningful when the timeout is enabled.
  localparam bit         TIMEOUT_EN = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST  = TIMEOUT_EN ? 8'(HOLD_MAX - 1) : 8'd0;

  state_t     state_q,    state_d;
  logic [2:0] ptr_q,      ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] gnt_q,      gnt_d;
  logic [2:0] gnt_idx_q,  gnt_idx_d;
  logic       busy_q,     busy_d;
  logic       timeout_q,  timeout_d;

  // Rotate the request vector so that bit 0 corresponds to ptr_q; the lowest
  // set bit of the rotated vector is then the round-robin winner's offset.
  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic [2:0]  win_idx;

  assign req_dbl = {req, req};
  assign req_rot = 8'(req_dbl >> ptr_q);

  always_comb begin
    win_off = 3'd0;
    // Descending scan so the lowest set offset is the one left standing.
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
  end

  assign win_idx = ptr_q + win_off;  // 3-bit add wraps modulo 8

  logic rel_done;
  logic rel_drop;
  logic rel_hold;

  assign rel_done = done;
  assign rel_drop = ~req[gnt_idx_q];
  assign rel_hold = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req != 8'h00) begin
          gnt_idx_d  = win_idx;
          gnt_d      = 8'(1) << win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (rel_done || rel_drop || rel_hold) begin
          gnt_d     = 8'h00;
          busy_d    = 1'b0;
          ptr_d     = gnt_idx_q + 3'd1;
          state_d   = IDLE;
          // Only a pure timeout is flagged; a voluntary release in the same
          // cycle takes precedence.
          timeout_d = rel_hold && !rel_done && !rel_drop;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 8'h00;
      gnt_idx_q  <= 3'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
